// File: rtl/vga_scan_timing_if.sv
// Raster scan bundle from vga_scan_timing to its consumers.
//   h_cnt/v_cnt   : pixel and line index
//   hsync/vsync   : active-low sync pulses
//   valid         : counters lie inside the active area
//   pixel_tick    : counters advance at the next clk edge
//   frame_start   : one-clk pulse after the scan wraps to (0,0)
// master = timing generator, slave = renderers / pin drivers.
interface vga_scan_timing_if;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hsync;
  logic       vsync;
  logic       valid;
  logic       pixel_tick;
  logic       frame_start;

  modport master (
    output h_cnt, v_cnt, hsync, vsync, valid, pixel_tick, frame_start
  );

  modport slave (
    input  h_cnt, v_cnt, hsync, vsync, valid, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_scan_timing.sv
// VGA raster scan generator.
// Divides clk by CLK_DIV to a pixel rate and produces the horizontal and
// vertical counters, active-low syncs, active-video flag and frame strobe.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   scan  : raster outputs (vga_scan_timing_if master modport)
module vga_scan_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_scan_timing_if.master  scan
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;
  logic             tick;

  // With CLK_DIV=1 div is stuck at 0 == DIV_LAST, so tick is 1 even in reset.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h_d     = h_q;
    v_d     = v_q;
    frame_d = 1'b0;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    // Decode from next-state counters so the registered flags line up
    // with the counter values they describe.
    hsync_d = !((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END));
    vsync_d = !((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END));
    valid_d = (h_d < H_ACT) && (v_d < V_ACT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign scan.h_cnt       = h_q;
  assign scan.v_cnt       = v_q;
  assign scan.hsync       = hsync_q;
  assign scan.vsync       = vsync_q;
  assign scan.valid       = valid_q;
  assign scan.pixel_tick  = tick;
  assign scan.frame_start = frame_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing using a reduced raster (30x19, active 16x12)
// so full frames fit in a short run; a second instance uses CLK_DIV=1.
module tb_vga_scan_timing;
  localparam int HA = 16, HFP = 4, HS = 6, HB = 4;
  localparam int VA = 12, VFP = 2, VS = 2, VB = 3;
  localparam int HT = HA + HFP + HS + HB;   // 30
  localparam int VT = VA + VFP + VS + VB;   // 19
  localparam int DIV = 4;
  localparam int FRAME4 = HT * VT * DIV;    // 2280
  localparam int FRAME1 = HT * VT;          // 570

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_scan_timing_if scan ();
  vga_scan_timing_if scan1 ();

  vga_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .scan(scan)
  );

  vga_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .scan(scan1)
  );

  task automatic test_reset();
    bit fs_seen;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (scan.h_cnt !== 10'd0 || scan.v_cnt !== 10'd0) begin
      errors++; $display("FAIL reset_cnt: h=%0d v=%0d want 0 0", scan.h_cnt, scan.v_cnt);
    end
    checks++;
    if ({scan.hsync, scan.vsync, scan.valid, scan.frame_start} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: hs/vs/valid/fs=%b want 1100",
                         {scan.hsync, scan.vsync, scan.valid, scan.frame_start});
    end
    checks++;
    if (scan.pixel_tick !== 1'b0 || scan1.pixel_tick !== 1'b1) begin
      errors++; $display("FAIL reset_tick: div4=%b div1=%b want 0 1", scan.pixel_tick, scan1.pixel_tick);
    end
    rst_n = 1'b1;
    fs_seen = 0;
    @(negedge clk);  // edge 1
    if (scan.frame_start === 1'b1 || scan1.frame_start === 1'b1) fs_seen = 1;
    checks++;
    if (scan.valid !== 1'b1 || scan.h_cnt !== 10'd0) begin
      errors++; $display("FAIL release_edge1: valid=%b h=%0d want 1 0", scan.valid, scan.h_cnt);
    end
    repeat (2) begin
      @(negedge clk);
      if (scan.frame_start === 1'b1 || scan1.frame_start === 1'b1) fs_seen = 1;
    end
    checks++;  // after edge 3
    if (scan.pixel_tick !== 1'b1 || scan.h_cnt !== 10'd0) begin
      errors++; $display("FAIL release_edge3: tick=%b h=%0d want 1 0", scan.pixel_tick, scan.h_cnt);
    end
    @(negedge clk);  // edge 4
    if (scan.frame_start === 1'b1 || scan1.frame_start === 1'b1) fs_seen = 1;
    checks++;
    if (scan.h_cnt !== 10'd1) begin
      errors++; $display("FAIL release_edge4: h=%0d want 1", scan.h_cnt);
    end
    repeat (4) begin
      @(negedge clk);
      if (scan.frame_start === 1'b1 || scan1.frame_start === 1'b1) fs_seen = 1;
    end
    checks++;  // edge 8
    if (scan.h_cnt !== 10'd2 || scan1.h_cnt !== 10'd8) begin
      errors++; $display("FAIL release_edge8: h=%0d h1=%0d want 2 8", scan.h_cnt, scan1.h_cnt);
    end
    checks++;
    if (fs_seen) begin
      errors++; $display("FAIL no_fs_after_reset: frame_start seen=1 want 0");
    end
  endtask

  task automatic test_line_scan();
    bit   found;
    logic prev;
    int   n;
    logic [9:0] v_old;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      prev = scan.hsync; @(negedge clk);
      if (prev === 1'b1 && scan.hsync === 1'b0) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hsync_fall: not seen want seen"); end
    checks++;
    if (scan.h_cnt !== 10'(HA + HFP)) begin
      errors++; $display("FAIL hsync_start_h: h=%0d want %0d", scan.h_cnt, HA + HFP);
    end
    n = 0;
    while (scan.hsync === 1'b0 && n < 500) begin n++; @(negedge clk); end
    checks++;
    if (n != HS * DIV || scan.h_cnt !== 10'(HA + HFP + HS)) begin
      errors++; $display("FAIL hsync_width: clks=%0d end_h=%0d want %0d %0d",
                         n, scan.h_cnt, HS * DIV, HA + HFP + HS);
    end
    // valid run over one active line
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      prev = scan.valid; @(negedge clk);
      if (prev === 1'b0 && scan.valid === 1'b1) found = 1;
    end
    checks++;
    if (!found || scan.h_cnt !== 10'd0) begin
      errors++; $display("FAIL valid_rise: found=%0d h=%0d want 1 0", found, scan.h_cnt);
    end
    n = 0;
    while (scan.valid === 1'b1 && n < 500) begin n++; @(negedge clk); end
    checks++;
    if (n != HA * DIV || scan.h_cnt !== 10'(HA)) begin
      errors++; $display("FAIL valid_width: clks=%0d end_h=%0d want %0d %0d", n, scan.h_cnt, HA * DIV, HA);
    end
    // line wrap
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (scan.h_cnt === 10'(HT - 1) && scan.pixel_tick === 1'b1) found = 1;
    end
    v_old = scan.v_cnt;
    @(negedge clk);
    checks++;
    if (!found || scan.h_cnt !== 10'd0 || scan.v_cnt !== 10'((int'(v_old) + 1) % VT)) begin
      errors++; $display("FAIL line_wrap: found=%0d h=%0d v=%0d want 1 0 %0d",
                         found, scan.h_cnt, scan.v_cnt, (int'(v_old) + 1) % VT);
    end
  endtask

  task automatic test_vsync();
    bit   found;
    logic prev;
    int   n;
    found = 0;
    for (int i = 0; i < 2500 && !found; i++) begin
      prev = scan.vsync; @(negedge clk);
      if (prev === 1'b1 && scan.vsync === 1'b0) found = 1;
    end
    checks++;
    if (!found || scan.v_cnt !== 10'(VA + VFP) || scan.h_cnt !== 10'd0) begin
      errors++; $display("FAIL vsync_fall: found=%0d v=%0d h=%0d want 1 %0d 0",
                         found, scan.v_cnt, scan.h_cnt, VA + VFP);
    end
    n = 0;
    while (scan.vsync === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    checks++;
    if (n != VS * HT * DIV || scan.v_cnt !== 10'(VA + VFP + VS)) begin
      errors++; $display("FAIL vsync_width: clks=%0d end_v=%0d want %0d %0d",
                         n, scan.v_cnt, VS * HT * DIV, VA + VFP + VS);
    end
  endtask

  task automatic test_frame_wrap();
    bit found;
    int start;
    found = 0;
    for (int i = 0; i < 2500 && !found; i++) begin
      @(negedge clk);
      if (scan.h_cnt === 10'(HT - 1) && scan.v_cnt === 10'(VT - 1) && scan.pixel_tick === 1'b1) found = 1;
    end
    checks++;
    if (!found || scan.frame_start !== 1'b0) begin
      errors++; $display("FAIL frame_last: found=%0d fs=%b want 1 0", found, scan.frame_start);
    end
    @(negedge clk);
    start = cyc;
    checks++;
    if (scan.h_cnt !== 10'd0 || scan.v_cnt !== 10'd0 || scan.frame_start !== 1'b1) begin
      errors++; $display("FAIL frame_wrap: h=%0d v=%0d fs=%b want 0 0 1", scan.h_cnt, scan.v_cnt, scan.frame_start);
    end
    @(negedge clk);
    checks++;
    if (scan.frame_start !== 1'b0) begin
      errors++; $display("FAIL fs_width: fs=%b want 0", scan.frame_start);
    end
    found = 0;
    for (int i = 0; i < 2500 && !found; i++) begin
      @(negedge clk);
      if (scan.frame_start === 1'b1) found = 1;
    end
    checks++;
    if (!found || (cyc - start) != FRAME4) begin
      errors++; $display("FAIL frame_period: found=%0d clks=%0d want 1 %0d", found, cyc - start, FRAME4);
    end
  endtask

  task automatic test_sprite_window();
    int pix, bad;
    int x, y;
    pix = 0; bad = 0;
    // aligned: frame_start is high now, scan at (0,0)
    for (int i = 0; i < FRAME4; i++) begin
      x = int'(scan.h_cnt) >> 1;
      y = int'(scan.v_cnt) >> 1;
      if (x >= 3 && x < 6 && y >= 2 && y < 5) begin
        if (scan.valid !== 1'b1) bad++;
        if (scan.pixel_tick === 1'b1) pix++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL window_valid: invalid_clks=%0d want 0", bad); end
    checks++;
    if (pix != 36) begin errors++; $display("FAIL window_pixels: count=%0d want 36", pix); end
  endtask

  task automatic test_mid_frame_reset();
    bit found;
    found = 0;
    for (int i = 0; i < 2500 && !found; i++) begin
      @(negedge clk);
      if (scan.h_cnt === 10'd25 && scan.v_cnt === 10'd15) found = 1;
    end
    checks++;
    if (!found || scan.hsync !== 1'b0 || scan.vsync !== 1'b0) begin
      errors++; $display("FAIL pre_reset: found=%0d hs=%b vs=%b want 1 0 0", found, scan.hsync, scan.vsync);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({scan.hsync, scan.vsync, scan.valid} !== 3'b110 || scan.h_cnt !== 10'd0 || scan.v_cnt !== 10'd0) begin
      errors++; $display("FAIL async_reset: hs/vs/valid=%b h=%0d v=%0d want 110 0 0",
                         {scan.hsync, scan.vsync, scan.valid}, scan.h_cnt, scan.v_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (scan.h_cnt !== 10'd0 || scan.v_cnt !== 10'd0 || scan.valid !== 1'b1 || scan.frame_start !== 1'b0) begin
      errors++; $display("FAIL restart_edge1: h=%0d v=%0d valid=%b fs=%b want 0 0 1 0",
                         scan.h_cnt, scan.v_cnt, scan.valid, scan.frame_start);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (scan.h_cnt !== 10'd1 || scan.v_cnt !== 10'd0) begin
      errors++; $display("FAIL restart_edge4: h=%0d v=%0d want 1 0", scan.h_cnt, scan.v_cnt);
    end
  endtask

  task automatic test_clk_div1();
    bit found;
    int start, bad;
    logic [9:0] prev_h;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      prev_h = scan1.h_cnt;
      @(negedge clk);
      if (scan1.pixel_tick !== 1'b1 || scan1.h_cnt !== 10'((int'(prev_h) + 1) % HT)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL div1_step: bad_clks=%0d want 0", bad); end
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (scan1.frame_start === 1'b1) found = 1;
    end
    start = cyc;
    checks++;
    if (!found || scan1.h_cnt !== 10'd0 || scan1.v_cnt !== 10'd0) begin
      errors++; $display("FAIL div1_wrap: found=%0d h=%0d v=%0d want 1 0 0", found, scan1.h_cnt, scan1.v_cnt);
    end
    @(negedge clk);
    checks++;
    if (scan1.frame_start !== 1'b0) begin
      errors++; $display("FAIL div1_fs_width: fs=%b want 0", scan1.frame_start);
    end
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (scan1.frame_start === 1'b1) found = 1;
    end
    checks++;
    if (!found || (cyc - start) != FRAME1) begin
      errors++; $display("FAIL div1_period: found=%0d clks=%0d want 1 %0d", found, cyc - start, FRAME1);
    end
  endtask

  initial begin
    test_reset();
    test_line_scan();
    test_vsync();
    test_frame_wrap();
    test_sprite_window();
    test_mid_frame_reset();
    test_clk_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

Generates the raster scan that every sprite renderer in the display path consumes. It divides the system clock down to a pixel rate and produces the horizontal and vertical pixel counters (`h_cnt`, `v_cnt`), active-low sync pulses, an active-video flag and a per-frame strobe. Sprite/object draw blocks compare against `h_cnt`/`v_cnt` combinationally (down-scaled by `>>1` for the 320x240 asset space). The top level drives the VGA pins with `hsync`/`vsync` and gates RGB with `valid`. Game-state logic uses `frame_start` to update once per frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync pulse width (pixels)
- `H_BP`, 48: horizontal back porch (pixels)
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync pulse width (lines)
- `V_BP`, 33: vertical back porch (lines)
- `CLK_DIV`, 4: system clocks per pixel (≥1); 100 MHz / 4 = 25 MHz

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `h_cnt`  out  10  horizontal pixel index, 0..H_TOTAL-1
- `v_cnt`  out  10  line index, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `valid`  out  1  high when (`h_cnt`,`v_cnt`) lies in the active area
- `pixel_tick`  out  1  high for the one clk in which the counters advance at the next edge
- `frame_start`  out  1  one-clk pulse after the counters wrap to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024. That is not checked in RTL.
- Divider `div` counts 0..CLK_DIV-1 every clk and wraps. `pixel_tick` = (`div` == CLK_DIV-1), decoded from the register. When CLK_DIV=1, `pixel_tick` is constantly 1 out of reset.
- On a clk edge with `pixel_tick`=1:
  - `h_cnt` increments.
  - When `h_cnt` == H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - When `v_cnt` == V_TOTAL-1 at the same time, `v_cnt` wraps to 0.
- Without `pixel_tick`, the counters hold.
- `hsync`, `vsync` and `valid` are registered. Each edge loads them from the decode of the counters' next-state values, so they are always aligned with the visible `h_cnt`/`v_cnt`. There is no lag.
  - `hsync`=0 iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751)
  - `vsync`=0 iff V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491)
  - `valid`=1 iff h < H_ACTIVE and v < V_ACTIVE
- `frame_start` is registered. It is 1 in the clk following the tick edge that wrapped both counters to (0,0). It is never asserted as a result of reset.
- Reset (async, any time, including mid-frame) forces:
  - `div`=0, `h_cnt`=0, `v_cnt`=0
  - `hsync`=1, `vsync`=1
  - `valid`=0, `frame_start`=0
  - While `rst_n`=0, `pixel_tick` = (CLK_DIV==1).

## Timing
- The first edge after `rst_n` rises loads `valid`=1, `hsync`=1, `vsync`=1, consistent with (0,0). The counters stay at (0,0) until the first tick edge, which is edge CLK_DIV after release.
- Each pixel lasts exactly CLK_DIV clks. A line lasts H_TOTAL·CLK_DIV clks (3200). A frame lasts H_TOTAL·V_TOTAL·CLK_DIV clks (1,680,000).
- The `valid` falling edge coincides with `h_cnt` changing 639→640. The `hsync` falling edge coincides with `h_cnt` changing 655→656. The `vsync` falling edge coincides with `v_cnt` changing 489→490.
- `frame_start` period equals the frame length. Its pulse width is exactly 1 clk, independent of CLK_DIV.

## Test plan
- Reset/release:
  - Hold `rst_n`=0 for 5 clks. Expect all reset values.
  - After release, expect `valid`=1 at edge 1, `h_cnt`=1 at edge 4, and `h_cnt`=2 at edge 8.
- Line scan (CLK_DIV=4):
  - Expect `hsync` low for exactly 96·4=384 clks, starting when `h_cnt`=656.
  - Expect `valid` high for 640 consecutive pixels per active line.
  - Expect `h_cnt` 799→0 together with `v_cnt` incrementing.
- Frame wrap:
  - Expect `vsync` low only for `v_cnt` 490–491 (2·3200 clks).
  - Expect (799,524)→(0,0), then `frame_start`=1 for exactly 1 clk.
  - Expect no `frame_start` after the initial reset.
- Mid-frame reset:
  - Assert `rst_n`=0 asynchronously at `h_cnt`=700, `v_cnt`=491, not on a clk edge.
  - Expect outputs to change immediately to reset values: `hsync`=1, `vsync`=1, `valid`=0.
  - After release, expect the scan to restart from (0,0).
- CLK_DIV=1 build:
  - Expect `pixel_tick` held at 1 and `h_cnt` incrementing every clk.
  - Expect frame length of 420,000 clks and `frame_start` spacing of 420,000.
- Sprite-window check:
  - With `x = h_cnt>>1` and `y = v_cnt>>1`, expect `valid`=1 throughout the window x∈[265,275), y∈[125,135).
  - Expect exactly 20·20 = 400 active pixels per frame in that window.
